// File: rtl/pixel_fetch_server_if.sv
// Pixel read bus between the frame-memory side server, the VGA data
// controller (read_en/data) and the frame memory (mem_*).
interface pixel_fetch_server_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 19
);
    logic              read_en;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              underflow;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Server side: serves pops, issues memory reads
    modport master (
        input  read_en,
        input  mem_ack,
        input  mem_rdata,
        output data,
        output data_valid,
        output underflow,
        output mem_req,
        output mem_addr
    );

    // Environment side: consumer plus frame memory
    modport slave (
        output read_en,
        output mem_ack,
        output mem_rdata,
        input  data,
        input  data_valid,
        input  underflow,
        input  mem_req,
        input  mem_addr
    );
endinterface

// File: rtl/pixel_fetch_server.sv
// Pixel fetch server: prefetches pixels from frame memory into a small FIFO
// using a single-outstanding req/ack handshake, serves read_en pops with one
// cycle latency and restarts on the frame-start point of hcont/vcont.
module pixel_fetch_server #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 19,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8,
    parameter int SYNC_V     = 524,
    parameter int SYNC_H     = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [9:0]           hcont,
    input  logic [9:0]           vcont,
    pixel_fetch_server_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] FRAME_PIX   = ADDR_W'(H_ACTIVE * V_ACTIVE);
    // One slot stays free for the word that is in flight
    localparam logic [CNT_W-1:0]  FETCH_LIMIT = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] pix_addr_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              discard_r;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] data_r;
    logic              data_valid_r;
    logic              underflow_r;

    logic sync_match_s;
    logic sync_match_r;
    logic fs_s;
    logic ack_s;
    logic push_s;
    logic pop_req_s;
    logic pop_s;

    // Frame start fires only on the first cycle of a match, so stalled
    // counters cannot restart the frame twice.
    assign sync_match_s = (vcont == 10'(SYNC_V)) && (hcont == 10'(SYNC_H));
    assign fs_s         = sync_match_s && !sync_match_r;

    // A restart flushes the FIFO, so neither the acked word nor a pop survives it
    assign ack_s     = (state_r == REQ) && bus.mem_ack;
    assign push_s    = ack_s && !discard_r && !fs_s;
    assign pop_req_s = bus.read_en && !fs_s;
    assign pop_s     = pop_req_s && (count_r != CNT_W'(0));

    assign bus.mem_req    = mem_req_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.data       = data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.underflow  = underflow_r;

    // Previous frame-start match, for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_match_r <= 1'b0;
        end else begin
            sync_match_r <= sync_match_s;
        end
    end

    // Fetch FSM: one outstanding read, address counter, discard of a word
    // whose request straddled a frame restart
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            pix_addr_r <= {ADDR_W{1'b0}};
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            discard_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fs_s) begin
                        pix_addr_r <= {ADDR_W{1'b0}};
                    end else if (pix_addr_r >= FRAME_PIX) begin
                        state_r <= DONE;
                    end else if (count_r < FETCH_LIMIT) begin
                        state_r    <= REQ;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pix_addr_r;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                        discard_r <= 1'b0;
                        if (fs_s || discard_r) begin
                            pix_addr_r <= {ADDR_W{1'b0}};
                        end else begin
                            // Only entered below FRAME_PIX, so this saturates there
                            pix_addr_r <= pix_addr_r + ADDR_W'(1);
                        end
                    end else if (fs_s) begin
                        // Request must complete; its data belongs to the old frame
                        discard_r  <= 1'b1;
                        pix_addr_r <= {ADDR_W{1'b0}};
                    end else begin
                        state_r <= REQ;
                    end
                end
                DONE: begin
                    if (fs_s) begin
                        state_r    <= IDLE;
                        pix_addr_r <= {ADDR_W{1'b0}};
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                    discard_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage write port (contents are qualified by count, no reset needed)
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem[wr_ptr_r] <= bus.mem_rdata;
        end
    end

    // FIFO bookkeeping and the registered consumer outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            data_valid_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else if (fs_s) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            data_valid_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                data_r       <= fifo_mem[rd_ptr_r];
                rd_ptr_r     <= rd_ptr_r + PTR_W'(1);
                data_valid_r <= 1'b1;
            end else begin
                // No bypass: a pop against an empty FIFO is an underflow even
                // if a word is being pushed in the same cycle
                data_valid_r <= 1'b0;
                if (pop_req_s) begin
                    underflow_r <= 1'b1;
                end else begin
                    underflow_r <= underflow_r;
                end
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end
endmodule

// File: tb/tb_pixel_fetch_server.sv
// Directed bench for pixel_fetch_server with a reduced 16x4 frame. A memory
// responder and a scoreboard of acked words run inside the tick task.
module tb_pixel_fetch_server;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 19;
    localparam int H_ACT  = 16;
    localparam int V_ACT  = 4;
    localparam int DEPTH  = 8;
    localparam int SV     = 524;
    localparam int SH     = 0;
    localparam int FRAME  = H_ACT * V_ACT;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hcont;
    logic [9:0] vcont;

    pixel_fetch_server_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pixel_fetch_server #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
        .FIFO_DEPTH(DEPTH), .SYNC_V(SV), .SYNC_H(SH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hcont(hcont),
        .vcont(vcont),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] exp_data = '0;
    logic [DATA_W-1:0] ovr_data = '0;
    bit exp_valid = 1'b0, exp_under = 1'b0, exp_discard = 1'b0;
    bit sync_prev = 1'b0, seen_req = 1'b0, use_ovr = 1'b0;
    int exp_addr = 0, req_addr = 0, req_cycles = 0, ack_delay = 0;
    int pops = 0, last_req_len = 0;
    logic [ADDR_W-1:0] last_new_req = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the edge, take it, check outputs, run the memory responder
    task automatic tick(input bit rd);
        bit match, fs, ack_now, pop_ok;
        bus.read_en = rd;
        match   = (vcont == 10'(SV)) && (hcont == 10'(SH));
        fs      = match && !sync_prev;
        sync_prev = match;
        ack_now = bus.mem_ack;
        pop_ok  = rd && !fs && (sb.size() != 0);
        if (fs) begin
            sb.delete();
            exp_under = 1'b0;
            exp_valid = 1'b0;
            exp_addr  = 0;
            pops      = 0;
        end else if (pop_ok) begin
            exp_data  = sb.pop_front();
            exp_valid = 1'b1;
            pops++;
        end else begin
            exp_valid = 1'b0;
            if (rd) exp_under = 1'b1;
        end
        if (ack_now) begin
            if (!fs && !exp_discard) begin
                sb.push_back(bus.mem_rdata);
                exp_addr++;
            end
            exp_discard = 1'b0;
        end else if (fs && seen_req) begin
            exp_discard = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        chk("data_valid", 32'(bus.data_valid), 32'(exp_valid));
        chk("data", 32'(bus.data), 32'(exp_data));
        chk("underflow", 32'(bus.underflow), 32'(exp_under));
        if (bus.mem_ack) begin
            chk("req_drop", 32'(bus.mem_req), 32'(0));
            bus.mem_ack = 1'b0;
            seen_req    = 1'b0;
            req_cycles  = 0;
        end else if (bus.mem_req) begin
            if (!seen_req) begin
                chk("req_addr", 32'(bus.mem_addr), 32'(exp_addr));
                last_new_req = bus.mem_addr;
                req_addr = exp_addr;
                seen_req = 1'b1;
            end else begin
                chk("addr_hold", 32'(bus.mem_addr), 32'(req_addr));
            end
            req_cycles++;
            if (req_cycles > ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = use_ovr ? ovr_data : DATA_W'(req_addr);
                use_ovr       = 1'b0;
                last_req_len  = req_cycles;
            end
        end
    endtask

    task automatic frame_start(input bit rd, input int hold);
        hcont = 10'(SH);
        vcont = 10'(SV);
        for (int i = 0; i < hold; i++) tick(rd);
        hcont = 10'd5;
        vcont = 10'd0;
    endtask

    initial begin
        hcont = 10'd5;
        vcont = 10'd0;
        bus.read_en   = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_data", 32'(bus.data), 32'(0));
        chk("rst_valid", 32'(bus.data_valid), 32'(0));
        chk("rst_under", 32'(bus.underflow), 32'(0));
        chk("rst_req", 32'(bus.mem_req), 32'(0));
        chk("rst_addr", 32'(bus.mem_addr), 32'(0));
        @(negedge clock);
        reset = 1'b1;

        // Fill: addresses 0..6 fetched, then no further request
        ack_delay = 0;
        frame_start(1'b0, 1);
        for (int i = 0; i < 30; i++) tick(1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("fill_stop", 32'(bus.mem_req), 32'(0));
            tick(1'b0);
        end

        // Three back-to-back pops, fetch resumes at address 7
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            chk("pop_valid", 32'(bus.data_valid), 32'(1));
            chk("pop_data", 32'(bus.data), 32'(i));
        end
        chk("resume_addr", 32'(last_new_req), 32'(7));
        for (int i = 0; i < 15; i++) tick(1'b0);

        // Drain with memory stalled -> underflow, data holds last pixel
        ack_delay = 1000;
        for (int i = 0; i < 12; i++) tick(1'b1);
        chk("uf_set", 32'(bus.underflow), 32'(1));
        chk("uf_valid", 32'(bus.data_valid), 32'(0));
        chk("uf_data", 32'(bus.data), 32'(9));
        chk("stall_req", 32'(bus.mem_req), 32'(1));
        chk("stall_addr", 32'(bus.mem_addr), 32'(10));

        // Restart while a request is outstanding: the late word is discarded
        frame_start(1'b0, 1);
        chk("uf_clear", 32'(bus.underflow), 32'(0));
        for (int i = 0; i < 3; i++) tick(1'b0);
        ovr_data  = 24'hABCDEF;
        use_ovr   = 1'b1;
        ack_delay = 0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        chk("discard_empty", 32'(bus.underflow), 32'(1));
        chk("discard_valid", 32'(bus.data_valid), 32'(0));
        chk("discard_hold", 32'(bus.data), 32'(9));
        chk("restart_addr", 32'(last_new_req), 32'(0));

        // Slow memory: request held through five wait cycles
        ack_delay = 5;
        frame_start(1'b0, 1);
        chk("fs_uf_clear", 32'(bus.underflow), 32'(0));
        for (int i = 0; i < 20; i++) tick(1'b0);
        chk("ack_wait_len", 32'(last_req_len), 32'(6));
        tick(1'b1);
        chk("slow_valid", 32'(bus.data_valid), 32'(1));
        chk("slow_data", 32'(bus.data), 32'(0));

        // Stalled sync counters restart only once; then a full frame
        ack_delay = 0;
        frame_start(1'b0, 6);
        for (int i = 0; i < 1500 && pops < FRAME; i++) tick(1'b1);
        chk("frame_pops", 32'(pops), 32'(FRAME));
        chk("frame_last", 32'(bus.data), 32'(FRAME - 1));
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            chk("done_idle", 32'(bus.mem_req), 32'(0));
        end

        // Asynchronous reset in the middle of a request
        ack_delay = 1000;
        frame_start(1'b0, 1);
        for (int i = 0; i < 10 && !bus.mem_req; i++) tick(1'b0);
        chk("pre_rst_req", 32'(bus.mem_req), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("arst_req", 32'(bus.mem_req), 32'(0));
        chk("arst_addr", 32'(bus.mem_addr), 32'(0));
        chk("arst_data", 32'(bus.data), 32'(0));
        chk("arst_valid", 32'(bus.data_valid), 32'(0));
        chk("arst_under", 32'(bus.underflow), 32'(0));
        bus.mem_ack = 1'b0;
        sb.delete();
        exp_data = '0; exp_valid = 1'b0; exp_under = 1'b0; exp_discard = 1'b0;
        exp_addr = 0; seen_req = 1'b0; req_cycles = 0; sync_prev = 1'b0;
        ack_delay = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick(1'b0);
        tick(1'b1);
        chk("post_rst_data", 32'(bus.data), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
